// File: rtl/mrdy_pkg.sv
// Shared types and constants for the MRDY wait-state generator.
package mrdy_pkg;

  localparam int WS_W = 4;  // wait-state counter width
  localparam int TO_W = 8;  // watchdog counter width

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_ROM,
    REG_UART,
    REG_EXT
  } region_e;

  // {QX,EX} phase encodings from the E/Q clock generator
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // Priority decode of the active-low selects: EXT > UART > ROM0/ROM1 > RAM
  function automatic region_e region_dec(input logic ncsram, input logic ncsrom0,
                                         input logic ncsrom1, input logic ncsuart,
                                         input logic ncsext);
    if (!ncsext)                 return REG_EXT;
    else if (!ncsuart)           return REG_UART;
    else if (!ncsrom0 || !ncsrom1) return REG_ROM;
    else if (!ncsram)            return REG_RAM;
    else                         return REG_NONE;
  endfunction

endpackage

// File: rtl/mrdy_gen_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLKX4,
  input  logic nRESET,
  input  logic d,
  output logic q
);

  logic s1;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge CLKX4) begin
    if (!nRESET) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/mrdy_gen.sv
// MRDY wait-state generator: stretches the E-high phase by a per-region
// count of CLKX4 periods, plus external-bus wait.
// Optional watchdog/bus-error logic enabled by defining MRDY_TIMEOUT_EN.
import mrdy_pkg::*;

module mrdy_gen #(
  parameter int WS_RAM  = 0,
  parameter int WS_ROM  = 1,
  parameter int WS_UART = 2,
  parameter int WS_EXT  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic CLKX4,
  input  logic nRESET,
  input  logic QX,
  input  logic EX,
  input  logic nCSRAM,
  input  logic nCSROM0,
  input  logic nCSROM1,
  input  logic nCSUART,
  input  logic nCSEXT,
  input  logic EXT_nWAIT,
  input  logic BUSERR_CLR,
  output logic MRDY,
  output logic STRETCH,
  output logic BUSERR
);

  localparam logic [WS_W-1:0] WS_RAM_L  = WS_RAM[WS_W-1:0];
  localparam logic [WS_W-1:0] WS_ROM_L  = WS_ROM[WS_W-1:0];
  localparam logic [WS_W-1:0] WS_UART_L = WS_UART[WS_W-1:0];
  localparam logic [WS_W-1:0] WS_EXT_L  = WS_EXT[WS_W-1:0];

  logic [1:0]      ph;
  region_e         reg_d, reg_q, reg_n;
  logic [WS_W-1:0] ws_d, cnt, cnt_d;
  logic            ext_sync, rdy_11, rdy_01;
  logic            mrdy_d, stretch_d, wd_hit;

  assign ph = {QX, EX};

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .CLKX4  (CLKX4),
    .nRESET (nRESET),
    .d      (EXT_nWAIT),
    .q      (ext_sync)
  );

  // Region decode and its wait count, valid at the 11 edge
  always_comb begin
    reg_d = region_dec(nCSRAM, nCSROM0, nCSROM1, nCSUART, nCSEXT);
    ws_d  = '0;
    case (reg_d)
      REG_RAM:  ws_d = WS_RAM_L;
      REG_ROM:  ws_d = WS_ROM_L;
      REG_UART: ws_d = WS_UART_L;
      REG_EXT:  ws_d = WS_EXT_L;
      default:  ws_d = '0;
    endcase
  end

  // External wait only matters for EXT cycles; the 11 edge uses the region
  // being latched, the 01 edges use the latched one.
  assign rdy_11 = (reg_d != REG_EXT) || ext_sync;
  assign rdy_01 = (reg_q != REG_EXT) || ext_sync;

  // Next MRDY/STRETCH/count per generator phase
  always_comb begin
    mrdy_d    = 1'b1;
    stretch_d = 1'b0;
    cnt_d     = cnt;
    reg_n     = reg_q;
    case (ph)
      PH_11: begin
        cnt_d     = ws_d;
        reg_n     = reg_d;
        mrdy_d    = (ws_d == '0) && rdy_11;
        stretch_d = !mrdy_d;
      end
      PH_01: begin
        if (!MRDY) begin
          if (cnt != '0) cnt_d = cnt - WS_W'(1);
          mrdy_d    = ((cnt <= WS_W'(1)) && rdy_01) || wd_hit;
          stretch_d = !mrdy_d;
        end
      end
      default: ;
    endcase
  end

  // Ready/stretch/count registers
  always_ff @(posedge CLKX4) begin
    if (!nRESET) begin
      MRDY    <= 1'b1;
      STRETCH <= 1'b0;
      cnt     <= '0;
      reg_q   <= REG_NONE;
    end else begin
      MRDY    <= mrdy_d;
      STRETCH <= stretch_d;
      cnt     <= cnt_d;
      reg_q   <= reg_n;
    end
  end

`ifdef MRDY_TIMEOUT_EN
  localparam logic [TO_W:0] TO_LIM = TIMEOUT[TO_W:0];

  logic [TO_W-1:0] wd;

  // The edge that brings the watchdog to TIMEOUT forces the cycle to end
  assign wd_hit = (ph == PH_01) && !MRDY && (({1'b0, wd} + 9'd1) >= TO_LIM);

  // Watchdog counts stretched 01 edges; BUSERR is sticky, set beats clear
  always_ff @(posedge CLKX4) begin
    if (!nRESET) begin
      wd     <= '0;
      BUSERR <= 1'b0;
    end else begin
      if (ph == PH_11)
        wd <= '0;
      else if ((ph == PH_01) && !MRDY && (wd != '1))
        wd <= wd + TO_W'(1);
      if (wd_hit)
        BUSERR <= 1'b1;
      else if (BUSERR_CLR)
        BUSERR <= 1'b0;
    end
  end
`else
  logic unused_buserr_clr;

  assign wd_hit            = 1'b0;
  assign BUSERR            = 1'b0;
  assign unused_buserr_clr = BUSERR_CLR;
`endif

endmodule
